// File: rtl/invaders_video_irq.sv
// Space Invaders video scan-out: raster counters, 1-bpp VRAM fetch and serialiser,
// plus the mid-screen (RST 1) and end-of-screen (RST 2) interrupt source.
module invaders_video_irq #(
  parameter int          H_TOTAL      = 320,
  parameter int          H_ACTIVE     = 256,
  parameter int          H_SYNC_START = 272,
  parameter int          H_SYNC_LEN   = 24,
  parameter int          V_TOTAL      = 262,
  parameter int          V_ACTIVE     = 224,
  parameter int          V_SYNC_START = 236,
  parameter int          V_SYNC_LEN   = 4,
  parameter int          MID_LINE     = 96,
  parameter int          END_LINE     = 224,
  parameter logic [15:0] VRAM_BASE    = 16'h2400
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ce,
  output logic [15:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic        pixel,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  input  logic        int_en,
  output logic        int_req,
  input  logic        int_ack,
  output logic [7:0]  int_data
);

  localparam int          HW             = $clog2(H_TOTAL);
  localparam int          VW             = $clog2(V_TOTAL);
  localparam logic [15:0] BYTES_PER_LINE = 16'(H_ACTIVE / 8);

  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic [15:0]   vram_addr_q, vram_addr_d;
  logic          vram_rd_q, rd_dly_q;
  logic [7:0]    hold_q, shift_q, shift_d;
  logic [7:0]    de_pipe_q, hs_pipe_q, vs_pipe_q;
  logic          pend_mid_q, pend_mid_d, pend_end_q, pend_end_d;
  logic          int_req_q;

  logic h_last, v_last, active, fetch, load, hs_raw, vs_raw, set_mid, set_end;

  assign h_last  = int'(hcount_q) == H_TOTAL - 1;
  assign v_last  = int'(vcount_q) == V_TOTAL - 1;
  assign active  = (int'(hcount_q) < H_ACTIVE) && (int'(vcount_q) < V_ACTIVE);
  assign fetch   = pix_ce && active && (hcount_q[2:0] == 3'd0);
  assign load    = pix_ce && active && (hcount_q[2:0] == 3'd7);
  assign hs_raw  = (int'(hcount_q) >= H_SYNC_START) && (int'(hcount_q) < H_SYNC_START + H_SYNC_LEN);
  assign vs_raw  = (int'(vcount_q) >= V_SYNC_START) && (int'(vcount_q) < V_SYNC_START + V_SYNC_LEN);
  assign set_mid = pix_ce && (hcount_q == '0) && (int'(vcount_q) == MID_LINE);
  assign set_end = pix_ce && (hcount_q == '0) && (int'(vcount_q) == END_LINE);

  always_comb begin
    hcount_d    = h_last ? '0 : hcount_q + HW'(1);
    vcount_d    = vcount_q;
    if (h_last) vcount_d = v_last ? '0 : vcount_q + VW'(1);
    shift_d     = load ? hold_q : {1'b0, shift_q[7:1]};
    vram_addr_d = VRAM_BASE + 16'(vcount_q) * BYTES_PER_LINE + 16'(hcount_q >> 3);
  end

  // A set event in the same clk as an ack of that bit must leave it set.
  always_comb begin
    pend_mid_d = pend_mid_q;
    pend_end_d = pend_end_q;
    if (int_ack) begin
      if (pend_end_q) pend_end_d = 1'b0;
      else            pend_mid_d = 1'b0;
    end
    if (set_mid) pend_mid_d = 1'b1;
    if (set_end) pend_end_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      vram_addr_q <= '0;
      vram_rd_q   <= 1'b0;
      rd_dly_q    <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      de_pipe_q   <= '0;
      hs_pipe_q   <= '0;
      vs_pipe_q   <= '0;
      pend_mid_q  <= 1'b0;
      pend_end_q  <= 1'b0;
      int_req_q   <= 1'b0;
    end else begin
      vram_rd_q <= fetch;
      rd_dly_q  <= vram_rd_q;
      if (fetch)    vram_addr_q <= vram_addr_d;
      if (rd_dly_q) hold_q      <= vram_data;
      if (pix_ce) begin
        hcount_q  <= hcount_d;
        vcount_q  <= vcount_d;
        shift_q   <= shift_d;
        de_pipe_q <= {de_pipe_q[6:0], active};
        hs_pipe_q <= {hs_pipe_q[6:0], hs_raw};
        vs_pipe_q <= {vs_pipe_q[6:0], vs_raw};
      end
      pend_mid_q <= pend_mid_d;
      pend_end_q <= pend_end_d;
      int_req_q  <= int_en & (pend_mid_q | pend_end_q);
    end
  end

  always_comb begin
    int_data = 8'h00;
    if (pend_end_q)      int_data = 8'hD7;
    else if (pend_mid_q) int_data = 8'hCF;
  end

  assign vram_addr = vram_addr_q;
  assign vram_rd   = vram_rd_q;
  assign de        = de_pipe_q[7];
  assign pixel     = shift_q[0] & de_pipe_q[7];
  assign hsync     = hs_pipe_q[7];
  assign vsync     = vs_pipe_q[7];
  assign int_req   = int_req_q;

endmodule
